// File: rtl/memory_bus_arbiter.sv
// Two-master round-robin arbiter in front of a single-port memory.
// Latches each granted access, holds strobes for a fixed latency, then pulses a response.
module memory_bus_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int MEMORY_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_memory_read,
  input  logic                  m0_memory_write,
  input  logic [DATA_WIDTH-1:0] m0_address,
  input  logic [DATA_WIDTH-1:0] m0_write_data,
  output logic [DATA_WIDTH-1:0] m0_read_data,
  output logic                  m0_response,
  input  logic                  m1_memory_read,
  input  logic                  m1_memory_write,
  input  logic [DATA_WIDTH-1:0] m1_address,
  input  logic [DATA_WIDTH-1:0] m1_write_data,
  output logic [DATA_WIDTH-1:0] m1_read_data,
  output logic                  m1_response,
  output logic                  memory_read,
  output logic                  memory_write,
  output logic [DATA_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] write_data,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic                  grant,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  localparam logic [3:0] LAST = 4'(MEMORY_LATENCY - 1);

  state_t     state;
  logic [3:0] count;
  logic       pointer;
  logic       req0;
  logic       req1;
  logic       sel;
  logic       sel_write;

  // Pick the winner: a lone requester, or the pointer's choice on contention.
  always_comb begin
    req0      = m0_memory_read | m0_memory_write;
    req1      = m1_memory_read | m1_memory_write;
    sel       = 1'b0;
    if (req0 && req1)
      sel = pointer;
    else if (req1)
      sel = 1'b1;
    sel_write = sel ? m1_memory_write : m0_memory_write;
  end

  // Arbitration FSM with all bus and response outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      pointer      <= 1'b0;
      grant        <= 1'b0;
      busy         <= 1'b0;
      memory_read  <= 1'b0;
      memory_write <= 1'b0;
      address      <= '0;
      write_data   <= '0;
      m0_read_data <= '0;
      m1_read_data <= '0;
      m0_response  <= 1'b0;
      m1_response  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req0 || req1) begin
            grant        <= sel;
            pointer      <= ~sel;
            count        <= '0;
            busy         <= 1'b1;
            memory_write <= sel_write;
            memory_read  <= ~sel_write;
            address      <= sel ? m1_address : m0_address;
            write_data   <= sel ? m1_write_data : m0_write_data;
            state        <= BUSY;
          end
        end
        BUSY: begin
          if (count == LAST) begin
            memory_read  <= 1'b0;
            memory_write <= 1'b0;
            if (!memory_write) begin
              if (grant)
                m1_read_data <= read_data;
              else
                m0_read_data <= read_data;
            end
            m0_response <= ~grant;
            m1_response <= grant;
            state       <= RESP;
          end else begin
            count <= count + 4'd1;
          end
        end
        RESP: begin
          m0_response <= 1'b0;
          m1_response <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed bench for memory_bus_arbiter at latency 1 (u1) and latency 3 (u3).
// Both instances share master inputs; each has its own memory model.
module tb_memory_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_rd = 1'b0, m0_wr = 1'b0;
  logic        m1_rd = 1'b0, m1_wr = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;

  logic [31:0] a_m0_rdata, a_m1_rdata, a_addr, a_wdata, a_rdata;
  logic        a_m0_resp, a_m1_resp, a_rd, a_wr, a_grant, a_busy;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_addr, b_wdata, b_rdata;
  logic        b_m0_resp, b_m1_resp, b_rd, b_wr, b_grant, b_busy;

  logic [31:0] mem1 [0:63];
  logic [31:0] mem3 [0:63];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  memory_bus_arbiter #(.DATA_WIDTH(32), .MEMORY_LATENCY(1)) u1 (
    .clk(clk), .reset(reset),
    .m0_memory_read(m0_rd), .m0_memory_write(m0_wr),
    .m0_address(m0_addr), .m0_write_data(m0_wdata),
    .m0_read_data(a_m0_rdata), .m0_response(a_m0_resp),
    .m1_memory_read(m1_rd), .m1_memory_write(m1_wr),
    .m1_address(m1_addr), .m1_write_data(m1_wdata),
    .m1_read_data(a_m1_rdata), .m1_response(a_m1_resp),
    .memory_read(a_rd), .memory_write(a_wr),
    .address(a_addr), .write_data(a_wdata),
    .read_data(a_rdata), .grant(a_grant), .busy(a_busy)
  );

  memory_bus_arbiter #(.DATA_WIDTH(32), .MEMORY_LATENCY(3)) u3 (
    .clk(clk), .reset(reset),
    .m0_memory_read(m0_rd), .m0_memory_write(m0_wr),
    .m0_address(m0_addr), .m0_write_data(m0_wdata),
    .m0_read_data(b_m0_rdata), .m0_response(b_m0_resp),
    .m1_memory_read(m1_rd), .m1_memory_write(m1_wr),
    .m1_address(m1_addr), .m1_write_data(m1_wdata),
    .m1_read_data(b_m1_rdata), .m1_response(b_m1_resp),
    .memory_read(b_rd), .memory_write(b_wr),
    .address(b_addr), .write_data(b_wdata),
    .read_data(b_rdata), .grant(b_grant), .busy(b_busy)
  );

  assign a_rdata = mem1[a_addr[7:2]];
  assign b_rdata = mem3[b_addr[7:2]];

  // Memory models: reset preloads the word at 0x10.
  always @(posedge clk) begin
    if (reset) begin
      mem1[4] <= 32'h12345678;
      mem3[4] <= 32'hCAFEF00D;
    end else begin
      if (a_wr) mem1[a_addr[7:2]] <= a_wdata;
      if (b_wr) mem3[b_addr[7:2]] <= b_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    m0_rd = 0; m0_wr = 0; m1_rd = 0; m1_wr = 0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    reset = 0;
    chk("rst_rd", 32'(a_rd), 0);
    chk("rst_wr", 32'(a_wr), 0);
    chk("rst_addr", a_addr, 0);
    chk("rst_wdata", a_wdata, 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_grant", 32'(a_grant), 0);
    chk("rst_m0rd", a_m0_rdata, 0);
    chk("rst_m0resp", 32'(a_m0_resp), 0);

    // Single read by m0, L=1
    m0_rd = 1; m0_addr = 32'h10;
    tick();
    chk("r_rd", 32'(a_rd), 1);
    chk("r_wr", 32'(a_wr), 0);
    chk("r_addr", a_addr, 32'h10);
    chk("r_busy", 32'(a_busy), 1);
    chk("r_grant", 32'(a_grant), 0);
    tick();
    chk("r_rd_off", 32'(a_rd), 0);
    chk("r_resp", 32'(a_m0_resp), 1);
    chk("r_data", a_m0_rdata, 32'h12345678);
    chk("r_m1resp", 32'(a_m1_resp), 0);
    chk("r_m1data", a_m1_rdata, 0);
    chk("r_busy_resp", 32'(a_busy), 1);
    idle_all();
    tick();
    chk("r_resp_off", 32'(a_m0_resp), 0);
    chk("r_idle_busy", 32'(a_busy), 0);
    chk("r_addr_hold", a_addr, 32'h10);

    // Write by m1
    m1_wr = 1; m1_addr = 32'h20; m1_wdata = 32'hDEADBEEF;
    tick();
    chk("w_wr", 32'(a_wr), 1);
    chk("w_rd", 32'(a_rd), 0);
    chk("w_wdata", a_wdata, 32'hDEADBEEF);
    chk("w_addr", a_addr, 32'h20);
    chk("w_grant", 32'(a_grant), 1);
    tick();
    chk("w_resp", 32'(a_m1_resp), 1);
    chk("w_m0resp", 32'(a_m0_resp), 0);
    chk("w_m1data", a_m1_rdata, 0);
    chk("w_wr_off", 32'(a_wr), 0);
    idle_all();
    tick();

    // Readback by m0
    m0_rd = 1; m0_addr = 32'h20;
    tick();
    chk("rb_grant", 32'(a_grant), 0);
    tick();
    chk("rb_resp", 32'(a_m0_resp), 1);
    chk("rb_data", a_m0_rdata, 32'hDEADBEEF);
    idle_all();
    tick();

    // Continuous contention from reset
    reset = 1;
    tick();
    reset = 0;
    chk("c_rst_m0data", a_m0_rdata, 0);
    m0_rd = 1; m0_addr = 32'h10;
    m1_rd = 1; m1_addr = 32'h20;
    tick();
    chk("c_g0", 32'(a_grant), 0);
    chk("c_busy0", 32'(a_busy), 1);
    tick();
    chk("c_resp0_m0", 32'(a_m0_resp), 1);
    chk("c_resp0_m1", 32'(a_m1_resp), 0);
    tick();
    chk("c_idle", 32'(a_busy), 0);
    chk("c_idle_resp", 32'(a_m0_resp), 0);
    tick();
    chk("c_g1", 32'(a_grant), 1);
    chk("c_addr1", a_addr, 32'h20);
    tick();
    chk("c_resp1_m1", 32'(a_m1_resp), 1);
    chk("c_resp1_m0", 32'(a_m0_resp), 0);
    chk("c_data1", a_m1_rdata, 32'hDEADBEEF);
    tick();
    tick();
    chk("c_g2", 32'(a_grant), 0);
    tick();
    chk("c_resp2_m0", 32'(a_m0_resp), 1);
    tick();
    tick();
    chk("c_g3", 32'(a_grant), 1);
    idle_all();
    tick(); tick();

    // Latency 3 read on u3
    reset = 1;
    tick();
    reset = 0;
    tick();
    m0_rd = 1; m0_addr = 32'h10;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("l3_rd%0d", i), 32'(b_rd), 1);
      chk($sformatf("l3_addr%0d", i), b_addr, 32'h10);
      chk($sformatf("l3_resp%0d", i), 32'(b_m0_resp), 0);
    end
    tick();
    chk("l3_rd_off", 32'(b_rd), 0);
    chk("l3_resp", 32'(b_m0_resp), 1);
    chk("l3_data", b_m0_rdata, 32'hCAFEF00D);
    idle_all();
    tick();
    chk("l3_resp_off", 32'(b_m0_resp), 0);
    chk("l3_idle", 32'(b_busy), 0);

    // Read and write together on m0: write wins
    m0_rd = 1; m0_wr = 1; m0_addr = 32'h30; m0_wdata = 32'h55AA55AA;
    tick();
    chk("rw_wr", 32'(b_wr), 1);
    chk("rw_rd", 32'(b_rd), 0);
    chk("rw_wdata", b_wdata, 32'h55AA55AA);
    tick(); tick(); tick();
    chk("rw_resp", 32'(b_m0_resp), 1);
    chk("rw_data_kept", b_m0_rdata, 32'hCAFEF00D);
    idle_all();
    tick();

    // Reset in the second BUSY cycle aborts the access
    m0_rd = 1; m0_addr = 32'h10;
    tick();
    tick();
    chk("ab_busy2", 32'(b_rd), 1);
    reset = 1;
    idle_all();
    tick();
    chk("ab_rd", 32'(b_rd), 0);
    chk("ab_busy", 32'(b_busy), 0);
    chk("ab_resp", 32'(b_m0_resp), 0);
    chk("ab_data", b_m0_rdata, 0);
    reset = 0;
    m0_rd = 1; m1_rd = 1;
    m0_addr = 32'h10; m1_addr = 32'h10;
    tick();
    chk("ab_g0", 32'(b_grant), 0);
    chk("ab_rd_again", 32'(b_rd), 1);
    chk("ab_no_resp", 32'(b_m0_resp | b_m1_resp), 0);
    idle_all();
    tick(); tick(); tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
